// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 564;
  localparam int unsigned DEFAULT_DATA_WIDTH   = 8;
  localparam int unsigned DEFAULT_STOP_BITS    = 1;

  // Whole-frame duration in clk cycles: start bit, data bits, stop bits.
  function automatic int unsigned frame_cycles(input int unsigned data_width,
                                               input int unsigned clks_per_bit,
                                               input int unsigned stop_bits);
    return (1 + data_width + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int unsigned CW = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          wrap_c
);

  assign wrap_c = (count == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || clear || wrap_c) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from a FIFO and sends them as 8N1/8N2 frames on txd.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = DEFAULT_STOP_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  txd_d, pop_d, busy_d, done_d;

  logic          baud_clear_c, baud_wrap_c, pre_wrap_c;
  logic [CW-1:0] baud_count;
  logic          start_ok_c, last_stop_c, launch_c;

  // Counter is held at zero while idle so the first start-bit cycle is count 0.
  assign baud_clear_c = (state_q == S_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (baud_clear_c),
    .count   (baud_count),
    .wrap_c  (baud_wrap_c)
  );

  assign pre_wrap_c  = (baud_count == CW'(CLKS_PER_BIT - 2));
  assign start_ok_c  = enable && !fifo_empty;
  assign last_stop_c = (stop_idx_q == 1'(STOP_BITS - 1));
  // A new frame starts from idle or directly out of the final stop cycle.
  assign launch_c    = start_ok_c &&
                       ((state_q == S_IDLE) ||
                        ((state_q == S_STOP) && last_stop_c && baud_wrap_c));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    txd_d      = txd;
    pop_d      = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
      end
      S_START: begin
        if (baud_wrap_c) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_wrap_c) begin
          if (bit_idx_q == IW'(DATA_WIDTH - 1)) begin
            state_d    = S_STOP;
            stop_idx_d = 1'b0;
            txd_d      = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
      S_STOP: begin
        // Registered pulse lands on the final stop cycle.
        done_d = last_stop_c && pre_wrap_c;
        if (baud_wrap_c) begin
          if (last_stop_c) begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Head word is latched on the same edge that issues the pop.
    if (launch_c) begin
      state_d   = S_START;
      shift_d   = fifo_data;
      bit_idx_d = '0;
      pop_d     = 1'b1;
      txd_d     = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      txd        <= 1'b1;
      fifo_pop   <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      txd        <= txd_d;
      fifo_pop   <= pop_d;
      busy       <= busy_d;
      tx_done    <= done_d;
    end
  end

endmodule
